icache_bk_control: RTL and testbench
====================================

Name: icache_bk_control

Overview:
- Control FSM for the 2-way set-associative instruction cache.
- Sits directly upstream of the per-way valid/tag arrays and the per-set LRU bit array (1 bit per set, async read, sync write).
- Drives their load/index/datain and consumes their dataout to detect hits, choose victims and sequence line fills from physical memory.
- The datapath (data arrays, read mux) is outside this block; it takes way_sel and load_data from here.

Parameters:
- s_offset, 5, byte-offset bits per line (32-byte line).
- s_index, 3, set-index bits (8 sets).
- s_tag, 24, tag bits (32 - s_index - s_offset).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_read  in  1  CPU fetch request, held until mem_resp
- mem_address  in  32  CPU fetch byte address
- mem_resp  out  1  fetch complete; data valid this cycle via way_sel
- pmem_read  out  1  line-fill request to memory, held until pmem_resp
- pmem_address  out  32  line-aligned fill address
- pmem_resp  in  1  fill line present on memory bus this cycle
- index  out  s_index  set index to all arrays (mem_address[s_offset+s_index-1:s_offset])
- valid_out  in  2  valid bit per way from valid arrays
- tag_out  in  2*s_tag  tag per way from tag arrays, way0 in low bits
- lru_out  in  1  LRU bit of indexed set (way to replace next)
- load_valid  out  2  valid-array write enable per way
- load_tag  out  2  tag-array write enable per way
- load_data  out  2  data-array write enable per way
- load_lru  out  1  LRU-array write enable
- valid_in  out  1  valid datain, always 1
- tag_in  out  s_tag  tag datain = mem_address tag field
- lru_in  out  1  LRU datain
- way_sel  out  1  way supplying the hit data

Behaviour:
- States: CHECK, FILL. Reset -> CHECK. Outputs are combinational from state and inputs.
- All load_* signals, mem_resp and pmem_read are 0 whenever mem_read=0 or rst=1.
- pmem_address = {tag, index, s_offset'b0} at all times.
- hit_w = valid_out[w] && tag_out[w] == tag. hit = hit_w0 | hit_w1.
- If both ways hit, way0 wins; this case is illegal but must not hang.
- CHECK, mem_read=1, hit:
  - mem_resp=1 in the same cycle.
  - way_sel = hit way.
  - load_lru=1, lru_in = ~way_sel.
  - Stay in CHECK. Zero-cycle hit latency.
- CHECK, mem_read=1, miss: no mem_resp; next state FILL.
- Victim choice:
  - Lowest-numbered invalid way, if any.
  - Otherwise lru_out.
  - Computed combinationally in FILL from the current array outputs. Index is stable because mem_read and mem_address are held.
- FILL:
  - pmem_read=1.
  - On pmem_resp=1: load_data[victim]=1, load_tag[victim]=1, load_valid[victim]=1; next state CHECK. The LRU is not written here.
  - Without pmem_resp: stay in FILL.
- After a fill, the following CHECK cycle hits. Miss latency = memory latency + 2 cycles from request to mem_resp.
- Back-to-back hits: a new address may be presented the cycle after mem_resp. There is no idle cycle.
- Reset in FILL: return to CHECK next cycle and drop pmem_read. Arrays are cleared by their own reset, so the following access misses.
- mem_read dropping mid-FILL is a protocol violation. The FSM stays in FILL until pmem_resp, then returns to CHECK.

Decomposition:
- Package icache_bk_pkg: state enum (CHECK, FILL); parameters s_offset, s_index, s_tag; functions get_tag and get_index for address field extraction.
- One sub-module, icache_bk_hit_detect (combinational): inputs valid_out and tag_out and the tag; outputs hit, hit_way and victim.

Test Plan:
- Reset, then mem_read=1 at 0x0000_1040:
  - Cycle 0: miss.
  - Cycle 1: pmem_read=1, pmem_address=0x0000_1040.
  - Drive pmem_resp at cycle 3: load_data/tag/valid[0]=1 that cycle.
  - Cycle 4: mem_resp=1, way_sel=0, lru_in=1.
- Re-read 0x0000_1044 -> mem_resp=1 in the same cycle, way_sel=0, pmem_read never asserted.
- Read 0x0000_2040 (same set 2, new tag) -> fills way1 (invalid). The next hit gives way_sel=1, lru_in=0.
- Read 0x0000_3040 with both ways valid and lru=0 -> victim way0 is replaced. A subsequent 0x0000_1040 access misses; 0x0000_2040 still hits way1.
- Assert rst while in FILL with pmem_resp withheld -> pmem_read=0 the next cycle, state CHECK, no load_* pulses.
- Back-to-back hits on 0x0000_1040 and 0x0000_2040 in consecutive cycles -> mem_resp=1 on both cycles, lru_in alternating 1 then 0.

Source files
------------

// File: rtl/icache_bk_pkg.sv
// Shared types, geometry and address helpers for the
// 2-way instruction cache control block.
package icache_bk_pkg;

  localparam int s_offset = 5;
  localparam int s_index  = 3;
  localparam int s_tag    = 32 - s_index - s_offset;

  typedef enum logic {
    CHECK = 1'b0,
    FILL  = 1'b1
  } state_e;

  function automatic logic [s_tag-1:0] get_tag(
    input logic [31:0] a
  );
    return a[31 -: s_tag];
  endfunction

  function automatic logic [s_index-1:0] get_index(
    input logic [31:0] a
  );
    return a[s_offset +: s_index];
  endfunction

endpackage

// File: rtl/icache_bk_hit_detect.sv
// Hit detection and victim selection for a 2-way set.
// Ports: i_valid, i_tag_out (way0 low), i_tag, i_lru in;
//        o_hit, o_hit_way, o_victim out.
module icache_bk_hit_detect
  import icache_bk_pkg::*;
(
  input  logic [1:0]         i_valid,
  input  logic [2*s_tag-1:0] i_tag_out,
  input  logic [s_tag-1:0]   i_tag,
  input  logic               i_lru,
  output logic               o_hit,
  output logic               o_hit_way,
  output logic               o_victim
);

  logic w_hit0;
  logic w_hit1;

  assign w_hit0 = i_valid[0] &&
    (i_tag_out[s_tag-1:0] == i_tag);
  assign w_hit1 = i_valid[1] &&
    (i_tag_out[2*s_tag-1:s_tag] == i_tag);

  assign o_hit = w_hit0 | w_hit1;

  // A double hit is illegal; way0 takes it.
  assign o_hit_way = ~w_hit0 & w_hit1;

  // First invalid way wins over the LRU pick.
  always_comb begin
    o_victim = i_lru;
    priority case (1'b1)
      ~i_valid[0]: o_victim = 1'b0;
      ~i_valid[1]: o_victim = 1'b1;
      default:     o_victim = i_lru;
    endcase
  end

endmodule

// File: rtl/icache_bk_control.sv
// Control FSM for the 2-way set-associative I-cache.
// Ports: CPU side (mem_read/address/resp), memory side
// (pmem_read/address/resp), array side (index, valid/tag/
// lru outs in; load_*, *_in, way_sel out).
module icache_bk_control
  import icache_bk_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic [31:0]        mem_address,
  output logic               mem_resp,
  output logic               pmem_read,
  output logic [31:0]        pmem_address,
  input  logic               pmem_resp,
  output logic [s_index-1:0] index,
  input  logic [1:0]         valid_out,
  input  logic [2*s_tag-1:0] tag_out,
  input  logic               lru_out,
  output logic [1:0]         load_valid,
  output logic [1:0]         load_tag,
  output logic [1:0]         load_data,
  output logic               load_lru,
  output logic               valid_in,
  output logic [s_tag-1:0]   tag_in,
  output logic               lru_in,
  output logic               way_sel
);

  state_e           r_state;
  state_e           w_next;
  logic [s_tag-1:0] w_tag;
  logic             w_hit;
  logic             w_hit_way;
  logic             w_victim;
  logic             w_act;

  assign w_tag  = get_tag(mem_address);
  assign index  = get_index(mem_address);
  assign tag_in = w_tag;
  assign valid_in = 1'b1;
  assign pmem_address =
    {w_tag, index, {s_offset{1'b0}}};

  assign way_sel = w_hit_way;
  assign lru_in  = ~w_hit_way;

  // All side effects are gated by a live request.
  assign w_act = mem_read & ~rst;

  icache_bk_hit_detect u_hit (
    .i_valid   (valid_out),
    .i_tag_out (tag_out),
    .i_tag     (w_tag),
    .i_lru     (lru_out),
    .o_hit     (w_hit),
    .o_hit_way (w_hit_way),
    .o_victim  (w_victim)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= CHECK;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    load_valid = 2'b00;
    load_tag   = 2'b00;
    load_data  = 2'b00;
    load_lru   = 1'b0;
    unique case (r_state)
      CHECK: begin
        if (w_act) begin
          if (w_hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
          end else begin
            w_next = FILL;
          end
        end
      end
      FILL: begin
        pmem_read = w_act;
        // Leave FILL on the response even if the
        // request was dropped, so the FSM cannot stick.
        if (pmem_resp) begin
          w_next = CHECK;
          if (w_act) begin
            load_data[w_victim]  = 1'b1;
            load_tag[w_victim]   = 1'b1;
            load_valid[w_victim] = 1'b1;
          end
        end
      end
    endcase
    if (rst) w_next = CHECK;
  end

endmodule

// File: tb/tb_icache_bk_control.sv
// Self-checking bench for icache_bk_control with a
// behavioural model of the valid/tag/LRU arrays.
module tb_icache_bk_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        mem_resp;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic        pmem_resp;
  logic [2:0]  index;
  logic [1:0]  valid_out;
  logic [47:0] tag_out;
  logic        lru_out;
  logic [1:0]  load_valid;
  logic [1:0]  load_tag;
  logic [1:0]  load_data;
  logic        load_lru;
  logic        valid_in;
  logic [23:0] tag_in;
  logic        lru_in;
  logic        way_sel;

  always #5 clk = ~clk;

  icache_bk_control dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_resp    (pmem_resp),
    .index        (index),
    .valid_out    (valid_out),
    .tag_out      (tag_out),
    .lru_out      (lru_out),
    .load_valid   (load_valid),
    .load_tag     (load_tag),
    .load_data    (load_data),
    .load_lru     (load_lru),
    .valid_in     (valid_in),
    .tag_in       (tag_in),
    .lru_in       (lru_in),
    .way_sel      (way_sel)
  );

  // Array model: sync write, async read, sync clear.
  logic        m_v [2][8];
  logic [23:0] m_t [2][8];
  logic        m_l [8];

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 8; s++) begin
          m_v[w][s] <= 1'b0;
          m_t[w][s] <= '0;
        end
      for (int s = 0; s < 8; s++) m_l[s] <= 1'b0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (load_valid[w]) m_v[w][index] <= valid_in;
        if (load_tag[w])   m_t[w][index] <= tag_in;
      end
      if (load_lru) m_l[index] <= lru_in;
    end
  end

  assign valid_out = {m_v[1][index], m_v[0][index]};
  assign tag_out   = {m_t[1][index], m_t[0][index]};
  assign lru_out   = m_l[index];

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          cyc;
    logic        way;
    logic        lru;
    int          fill;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t sb[$];
  vec_t tbl[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Drive one request and follow it to mem_resp.
  task automatic do_access(input vec_t v);
    int   cyc;
    int   pcnt;
    int   fw;
    bit   got;
    bit   pseen;
    logic gway;
    logic glru;
    logic gll;
    logic [31:0] pa;
    vec_t e;
    mem_read    = 1'b1;
    mem_address = v.addr;
    sb.push_back(v);
    cyc = 0; pcnt = 0; fw = -1;
    got = 0; pseen = 0; pa = '0;
    gway = 0; glru = 0; gll = 0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      if (pmem_read) begin
        pseen = 1;
        pa = pmem_address;
        pcnt++;
        if (pcnt == v.lat) pmem_resp = 1'b1;
      end
      #1;
      if (|load_data) begin
        fw = load_data[1] ? 1 : 0;
        chk("load_tag_sync", {30'b0, load_tag},
            {30'b0, load_data});
        chk("load_valid_sync", {30'b0, load_valid},
            {30'b0, load_data});
      end
      if (mem_resp) begin
        got  = 1;
        gway = way_sel;
        glru = lru_in;
        gll  = load_lru;
      end
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (!got) cyc++;
    end
    e = sb.pop_front();
    chk("resp_seen", {31'b0, got}, 32'd1);
    if (got) begin
      chk("resp_cycle", cyc, e.cyc);
      chk("way_sel", {31'b0, gway}, {31'b0, e.way});
      chk("lru_in", {31'b0, glru}, {31'b0, e.lru});
      chk("load_lru", {31'b0, gll}, 32'd1);
    end
    chk("fill_way", fw, e.fill);
    chk("pmem_used", {31'b0, pseen},
        {31'b0, (e.fill >= 0)});
    if (pseen)
      chk("pmem_addr", pa, e.addr & 32'hFFFF_FFE0);
  endtask

  initial begin
    tbl[0] = '{32'h0000_1040, 3, 4, 1'b0, 1'b1, 0};
    tbl[1] = '{32'h0000_1044, 0, 0, 1'b0, 1'b1, -1};
    tbl[2] = '{32'h0000_2040, 1, 2, 1'b1, 1'b0, 1};
    tbl[3] = '{32'h0000_3040, 2, 3, 1'b0, 1'b1, 0};
    tbl[4] = '{32'h0000_2040, 0, 0, 1'b1, 1'b0, -1};
    tbl[5] = '{32'h0000_1040, 1, 2, 1'b0, 1'b1, 0};
    tbl[6] = '{32'h0000_1040, 0, 0, 1'b0, 1'b1, -1};
    tbl[7] = '{32'h0000_2040, 0, 0, 1'b1, 1'b0, -1};
    tbl[8] = '{32'h0000_0060, 1, 2, 1'b0, 1'b1, 0};

    rst = 1'b1;
    mem_read = 1'b1;
    mem_address = 32'h0000_1040;
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("rst_mem_resp", {31'b0, mem_resp}, 32'd0);
    chk("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    chk("rst_load_lru", {31'b0, load_lru}, 32'd0);
    chk("rst_load_data", {30'b0, load_data}, 32'd0);
    chk("index", {29'b0, index}, 32'd2);
    chk("tag_in", {8'b0, tag_in}, 32'h10);
    chk("valid_in", {31'b0, valid_in}, 32'd1);
    chk("pmem_addr_comb", pmem_address, 32'h1040);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) do_access(tbl[i]);

    // Reset while a fill is outstanding.
    mem_address = 32'h0000_5040;
    @(negedge clk);
    chk("miss_no_pmem", {31'b0, pmem_read}, 32'd0);
    chk("miss_no_resp", {31'b0, mem_resp}, 32'd0);
    @(negedge clk);
    chk("fill_req", {31'b0, pmem_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_gate_pmem", {31'b0, pmem_read}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_drop_pmem", {31'b0, pmem_read}, 32'd0);
    chk("rst_no_resp", {31'b0, mem_resp}, 32'd0);
    chk("rst_no_load",
        {28'b0, load_data, load_valid}, 32'd0);
    @(negedge clk);
    chk("refill_req", {31'b0, pmem_read}, 32'd1);
    pmem_resp = 1'b1;
    #1;
    chk("refill_way0", {30'b0, load_data}, 32'd1);
    @(posedge clk);
    #1 pmem_resp = 1'b0;

    // Way0 holds 0x5040 now; way1 is the free way.
    do_access('{32'h0000_1040, 1, 2, 1'b1, 1'b0, 1});
    mem_read = 1'b0;
    @(negedge clk);
    chk("idle_resp", {31'b0, mem_resp}, 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
